// File: rtl/region_bbox_detect.sv
// region_bbox_detect: per-frame bounding box and foreground count of a binary pixel stream.
// Optional overlay output enabled by defining REGION_BBOX_OVERLAY_EN.
module region_bbox_detect #(
   parameter int IMG_W   = 640,
   parameter int IMG_H   = 480,
   parameter int CNT_W   = 11,
   parameter int MIN_PIX = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pre_img_vsync,
   input  logic               pre_img_hsync,
   input  logic               pre_img_valid,
   input  logic               pre_img_data,
   output logic               bbox_valid,
   output logic               bbox_found,
   output logic [CNT_W-1:0]   bbox_x_min,
   output logic [CNT_W-1:0]   bbox_x_max,
   output logic [CNT_W-1:0]   bbox_y_min,
   output logic [CNT_W-1:0]   bbox_y_max,
   output logic [2*CNT_W-1:0] bbox_pix_cnt,
   output logic               post_img_vsync,
   output logic               post_img_hsync,
   output logic               post_img_valid,
   output logic [7:0]         post_img_data
);
   typedef enum logic [1:0] {IDLE, ACTIVE, LATCH} state_t;
   localparam logic [CNT_W-1:0]   W_LIM   = CNT_W'(IMG_W);
   localparam logic [CNT_W-1:0]   H_LIM   = CNT_W'(IMG_H);
   localparam logic [CNT_W-1:0]   C_MAX   = '1;
   localparam logic [2*CNT_W-1:0] N_MAX   = '1;
   localparam logic [2*CNT_W-1:0] MIN_CNT = (2*CNT_W)'(MIN_PIX);
   state_t state;
   logic vsync_d, hsync_d, line_pix, fg_hit, found;
   logic [CNT_W-1:0] x, y, x_min, x_max, y_min, y_max;
   logic [2*CNT_W-1:0] cnt;
   assign fg_hit = state == ACTIVE && pre_img_valid && pre_img_data && x < W_LIM && y < H_LIM;
   assign found  = cnt >= MIN_CNT;
   // vsync_d resets high so a frame already running at reset release is not mistaken for a new one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         vsync_d      <= 1'b1;
         hsync_d      <= 1'b0;
         line_pix     <= 1'b0;
         x            <= '0;
         y            <= '0;
         x_min        <= '1;
         x_max        <= '0;
         y_min        <= '1;
         y_max        <= '0;
         cnt          <= '0;
         bbox_valid   <= 1'b0;
         bbox_found   <= 1'b0;
         bbox_x_min   <= '0;
         bbox_x_max   <= '0;
         bbox_y_min   <= '0;
         bbox_y_max   <= '0;
         bbox_pix_cnt <= '0;
      end else begin
         vsync_d    <= pre_img_vsync;
         hsync_d    <= pre_img_hsync;
         bbox_valid <= state == LATCH;
         case (state)
            IDLE: if (pre_img_vsync && !vsync_d) begin
               state    <= ACTIVE;
               line_pix <= 1'b0;
               x        <= '0;
               y        <= '0;
               x_min    <= '1;
               x_max    <= '0;
               y_min    <= '1;
               y_max    <= '0;
               cnt      <= '0;
            end
            ACTIVE: begin
               if (!pre_img_vsync && vsync_d) state <= LATCH;
               if (hsync_d && !pre_img_hsync) begin
                  x        <= '0;
                  line_pix <= 1'b0;
                  if ((line_pix || pre_img_valid) && y != C_MAX) y <= y + 1'b1;
               end else if (pre_img_valid) begin
                  line_pix <= 1'b1;
                  if (x != C_MAX) x <= x + 1'b1;
               end
               if (fg_hit) begin
                  x_min <= x < x_min ? x : x_min;
                  x_max <= x > x_max ? x : x_max;
                  y_min <= y < y_min ? y : y_min;
                  y_max <= y > y_max ? y : y_max;
                  cnt   <= cnt == N_MAX ? cnt : cnt + 1'b1;
               end
            end
            default: begin
               state        <= IDLE;
               bbox_found   <= found;
               bbox_x_min   <= found ? x_min : '0;
               bbox_x_max   <= found ? x_max : '0;
               bbox_y_min   <= found ? y_min : '0;
               bbox_y_max   <= found ? y_max : '0;
               bbox_pix_cnt <= cnt;
            end
         endcase
      end
   end
`ifdef REGION_BBOX_OVERLAY_EN
   logic in_x, in_y, on_edge;
   assign in_x    = x >= bbox_x_min && x <= bbox_x_max;
   assign in_y    = y >= bbox_y_min && y <= bbox_y_max;
   assign on_edge = bbox_found && ((in_y && (x == bbox_x_min || x == bbox_x_max)) ||
                                   (in_x && (y == bbox_y_min || y == bbox_y_max)));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         post_img_vsync <= 1'b0;
         post_img_hsync <= 1'b0;
         post_img_valid <= 1'b0;
         post_img_data  <= 8'h00;
      end else begin
         post_img_vsync <= pre_img_vsync;
         post_img_hsync <= pre_img_hsync;
         post_img_valid <= pre_img_valid;
         post_img_data  <= !pre_img_valid ? 8'h00 : on_edge ? 8'hFF : {8{pre_img_data}};
      end
   end
`else
   assign post_img_vsync = 1'b0;
   assign post_img_hsync = 1'b0;
   assign post_img_valid = 1'b0;
   assign post_img_data  = 8'h00;
`endif
endmodule

// File: tb/tb_region_bbox_detect.sv
// tb_region_bbox_detect: directed frames on a 16x8 image, two instances (MIN_PIX 1 and 4).
module tb_region_bbox_detect;
   logic clk = 1'b0, rst_n = 1'b0;
   logic vsync = 1'b0, hsync = 1'b0, valid = 1'b0, data = 1'b0;
   logic b_valid, b_found, p_vs, p_hs, p_v;
   logic [10:0] b_x0, b_x1, b_y0, b_y1;
   logic [21:0] b_cnt;
   logic [7:0] p_d;
   logic c_valid, c_found, q_vs, q_hs, q_v;
   logic [10:0] c_x0, c_x1, c_y0, c_y1;
   logic [21:0] c_cnt;
   logic [7:0] q_d;
   logic img [0:7][0:19];
   int n_chk = 0, n_fail = 0;
   logic m_found = 1'b0;
   int m_x0 = 0, m_x1 = 0, m_y0 = 0, m_y1 = 0;

   always #5 clk = ~clk;

   region_bbox_detect #(.IMG_W(16), .IMG_H(8), .CNT_W(11), .MIN_PIX(1)) dut (
      .clk(clk), .rst_n(rst_n), .pre_img_vsync(vsync), .pre_img_hsync(hsync),
      .pre_img_valid(valid), .pre_img_data(data), .bbox_valid(b_valid), .bbox_found(b_found),
      .bbox_x_min(b_x0), .bbox_x_max(b_x1), .bbox_y_min(b_y0), .bbox_y_max(b_y1),
      .bbox_pix_cnt(b_cnt), .post_img_vsync(p_vs), .post_img_hsync(p_hs),
      .post_img_valid(p_v), .post_img_data(p_d));

   region_bbox_detect #(.IMG_W(16), .IMG_H(8), .CNT_W(11), .MIN_PIX(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .pre_img_vsync(vsync), .pre_img_hsync(hsync),
      .pre_img_valid(valid), .pre_img_data(data), .bbox_valid(c_valid), .bbox_found(c_found),
      .bbox_x_min(c_x0), .bbox_x_max(c_x1), .bbox_y_min(c_y0), .bbox_y_max(c_y1),
      .bbox_pix_cnt(c_cnt), .post_img_vsync(q_vs), .post_img_hsync(q_hs),
      .post_img_valid(q_v), .post_img_data(q_d));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_img();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 20; c++) img[r][c] = 1'b0;
   endtask

   function automatic logic [7:0] ovl_exp(input int px, input int py, input logic d);
      logic edge_hit;
      edge_hit = m_found &&
         (((px == m_x0 || px == m_x1) && py >= m_y0 && py <= m_y1) ||
          ((py == m_y0 || py == m_y1) && px >= m_x0 && px <= m_x1));
      return edge_hit ? 8'hFF : {8{d}};
   endfunction

   // leading hsync-only line must not advance the line counter
   task automatic run_frame(input int npix);
      vsync = 1'b1; tick(); tick();
      hsync = 1'b1; tick(); tick(); hsync = 1'b0; tick();
      for (int r = 0; r < 8; r++) begin
         hsync = 1'b1;
         for (int c = 0; c < npix; c++) begin
            valid = 1'b1; data = img[r][c];
            tick();
`ifdef REGION_BBOX_OVERLAY_EN
            check("ovl_valid", {31'b0, p_v}, 32'd1);
            check("ovl_hsync", {31'b0, p_hs}, 32'd1);
            check("ovl_data", {24'b0, p_d}, {24'b0, ovl_exp(c, r, img[r][c])});
`else
            check("post_data_tied", {24'b0, p_d}, 32'd0);
`endif
         end
         valid = 1'b0; data = 1'b0; hsync = 1'b0;
         tick();
`ifdef REGION_BBOX_OVERLAY_EN
         check("ovl_idle", {24'b0, p_d}, 32'd0);
`endif
         tick();
      end
      vsync = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic f, input int x0, input int x1,
                               input int y0, input int y1, input int n, input logic f4);
      tick();
      check({tag, "_early"}, {31'b0, b_valid}, 32'd0);
      tick();
      check({tag, "_valid"}, {31'b0, b_valid}, 32'd1);
      check({tag, "_found"}, {31'b0, b_found}, {31'b0, f});
      check({tag, "_xmin"}, {21'b0, b_x0}, f ? x0 : 0);
      check({tag, "_xmax"}, {21'b0, b_x1}, f ? x1 : 0);
      check({tag, "_ymin"}, {21'b0, b_y0}, f ? y0 : 0);
      check({tag, "_ymax"}, {21'b0, b_y1}, f ? y1 : 0);
      check({tag, "_cnt"}, {10'b0, b_cnt}, n);
      check({tag, "_valid4"}, {31'b0, c_valid}, 32'd1);
      check({tag, "_found4"}, {31'b0, c_found}, {31'b0, f4});
      check({tag, "_xmin4"}, {21'b0, c_x0}, f4 ? x0 : 0);
      check({tag, "_ymax4"}, {21'b0, c_y1}, f4 ? y1 : 0);
      check({tag, "_cnt4"}, {10'b0, c_cnt}, n);
      m_found = f; m_x0 = x0; m_x1 = x1; m_y0 = y0; m_y1 = y1;
      tick();
      check({tag, "_pulse"}, {31'b0, b_valid}, 32'd0);
      check({tag, "_hold"}, {10'b0, b_cnt}, n);
   endtask

   initial begin
      tick(); tick();
      check("rst_valid", {31'b0, b_valid}, 32'd0);
      check("rst_found", {31'b0, b_found}, 32'd0);
      check("rst_cnt", {10'b0, b_cnt}, 32'd0);
      check("rst_post", {24'b0, p_d}, 32'd0);
      rst_n = 1'b1; tick(); tick();

      clear_img(); img[3][5] = 1'b1;
      run_frame(16); check_result("single", 1'b1, 5, 5, 3, 3, 1, 1'b0);

      clear_img(); img[1][2] = 1'b1; img[6][12] = 1'b1; img[4][7] = 1'b1;
      run_frame(16); check_result("three", 1'b1, 2, 12, 1, 6, 3, 1'b0);

      clear_img();
      run_frame(16); check_result("empty", 1'b0, 0, 0, 0, 0, 0, 1'b0);

      clear_img(); img[0][17] = 1'b1; img[4][17] = 1'b1; img[7][17] = 1'b1;
      run_frame(20); check_result("wide", 1'b0, 0, 0, 0, 0, 0, 1'b0);

      clear_img(); img[0][0] = 1'b1; img[7][15] = 1'b1; img[2][3] = 1'b1; img[5][8] = 1'b1;
      run_frame(16); check_result("corners", 1'b1, 0, 15, 0, 7, 4, 1'b1);

      // reset asserted and released inside a frame: that frame must never report
      vsync = 1'b1; tick(); tick();
      hsync = 1'b1; valid = 1'b1; data = 1'b1; tick(); tick();
      rst_n = 1'b0; #2;
      check("mid_rst_valid", {31'b0, b_valid}, 32'd0);
      check("mid_rst_cnt", {10'b0, b_cnt}, 32'd0);
      tick(); rst_n = 1'b1; tick(); tick();
      hsync = 1'b0; valid = 1'b0; data = 1'b0; tick();
      vsync = 1'b0; tick();
      check("mid_rst_n", {31'b0, b_valid}, 32'd0);
      tick();
      check("mid_rst_n1", {31'b0, b_valid}, 32'd0);
      tick();
      check("mid_rst_n2", {31'b0, b_valid}, 32'd0);
      check("mid_rst_found", {31'b0, b_found}, 32'd0);
      m_found = 1'b0;

      clear_img(); img[3][5] = 1'b1;
      run_frame(16); check_result("after_rst", 1'b1, 5, 5, 3, 3, 1, 1'b0);

      clear_img(); img[2][4] = 1'b1; img[5][9] = 1'b1;
      run_frame(16); check_result("ovl_box", 1'b1, 4, 9, 2, 5, 2, 1'b0);

      clear_img();
      run_frame(16); check_result("ovl_zero", 1'b0, 0, 0, 0, 0, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
